// File: rtl/gsim_band_solver.sv
// Gauss-Seidel solver for the symmetric 7-band system (-1, 6, -13, 20, -13, 6, -1) of size N.
// Latency: last accepted b sample to first out_valid = iter_cnt*N + 1 cycles.
// Backpressure: none; in_en is only accepted while idle (busy=0), samples offered while busy are dropped.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   in_en, b_in      b sample strobe and signed integer value, rows 0..N-1 in order
//   out_valid, x_out N-cycle burst of signed Q(XW-FRAC).FRAC solution, rows 0..N-1
//   busy             high from first solve cycle through last output cycle
//   iter_cnt         sweeps executed for the last/current problem
//   converged        last problem stopped on the tolerance rather than the sweep limit
module gsim_band_solver #(
  parameter int N        = 16,
  parameter int BW       = 16,
  parameter int XW       = 32,
  parameter int FRAC     = 16,
  parameter int MAX_ITER = 64,
  parameter int TOL      = 0,
  parameter int IW       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_en,
  input  logic signed [BW-1:0] b_in,
  output logic                 out_valid,
  output logic signed [XW-1:0] x_out,
  output logic                 busy,
  output logic [IW-1:0]        iter_cnt,
  output logic                 converged
);
  localparam int IXW = $clog2(N);
  // Numerator width: |b<<FRAC| plus 40 * max|x| fits in max(BW+FRAC, XW) + 6 bits; 8 leaves margin.
  localparam int AW  = (BW + FRAC > XW) ? (BW + FRAC) : XW;
  localparam int NW  = AW + 8;

  localparam logic [IXW-1:0]       LAST = IXW'(N - 1);
  localparam logic signed [NW-1:0] XMAX = {{(NW-XW+1){1'b0}}, {(XW-1){1'b1}}};
  localparam logic signed [NW-1:0] XMIN = {{(NW-XW+1){1'b1}}, {(XW-1){1'b0}}};
  localparam logic signed [NW-1:0] K6   = NW'(6);
  localparam logic signed [NW-1:0] K13  = NW'(13);
  localparam logic signed [NW-1:0] K20  = NW'(20);
  localparam logic signed [NW-1:0] TOLV = NW'(TOL);

  typedef enum logic [1:0] {S_LOAD, S_SOLVE, S_OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [IXW-1:0]        idx;
  logic signed [BW-1:0]  b_mem [N];
  logic signed [XW-1:0]  x_mem [N];
  logic signed [NW-1:0]  sweep_max;

  logic signed [NW-1:0]  s1, s2, s3, num, quo, diff, adiff, cur_max;
  logic signed [BW-1:0]  b_cur;
  logic signed [XW-1:0]  x_old, x_new;
  logic                  last_row, load_fire, stop_tol, stop_it;

  // The final output cycle already sits in LOAD, so it still counts as busy.
  assign busy      = (state_q != S_LOAD) || out_valid;
  assign load_fire = in_en && !busy;
  assign last_row  = (idx == LAST);

  // Row update for row idx; neighbours outside 0..N-1 simply never match and contribute 0.
  always_comb begin
    s1    = '0;
    s2    = '0;
    s3    = '0;
    b_cur = '0;
    x_old = '0;
    for (int j = 0; j < N; j++) begin
      if (j == int'(idx)) begin
        b_cur = b_mem[j];
        x_old = x_mem[j];
      end
      if (j == int'(idx) - 1 || j == int'(idx) + 1) s1 = s1 + NW'(x_mem[j]);
      if (j == int'(idx) - 2 || j == int'(idx) + 2) s2 = s2 + NW'(x_mem[j]);
      if (j == int'(idx) - 3 || j == int'(idx) + 3) s3 = s3 + NW'(x_mem[j]);
    end
    num = (NW'(b_cur) <<< FRAC) + K13 * s1 - K6 * s2 + s3;
    quo = num / K20;   // signed, truncates toward zero
    if (quo > XMAX)      x_new = XMAX[XW-1:0];
    else if (quo < XMIN) x_new = XMIN[XW-1:0];
    else                 x_new = quo[XW-1:0];
    diff    = NW'(x_new) - NW'(x_old);
    adiff   = diff[NW-1] ? -diff : diff;
    cur_max = (idx == '0 || adiff > sweep_max) ? adiff : sweep_max;
    stop_tol = (cur_max <= TOLV);
    stop_it  = (iter_cnt == IW'(MAX_ITER - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   if (load_fire && last_row) state_d = S_SOLVE;
      S_SOLVE:  if (last_row && (stop_tol || stop_it)) state_d = S_OUTPUT;
      S_OUTPUT: if (last_row) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      sweep_max <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      iter_cnt  <= '0;
      converged <= 1'b0;
      for (int i = 0; i < N; i++) begin
        b_mem[i] <= '0;
        x_mem[i] <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          out_valid <= 1'b0;
          if (load_fire) begin
            b_mem[idx] <= b_in;
            if (last_row) begin
              idx       <= '0;
              sweep_max <= '0;
              iter_cnt  <= '0;
              converged <= 1'b0;
              for (int i = 0; i < N; i++) x_mem[i] <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_SOLVE: begin
          x_mem[idx] <= x_new;
          sweep_max  <= cur_max;
          if (last_row) begin
            idx      <= '0;
            iter_cnt <= iter_cnt + IW'(1);
            // Tolerance wins when both stop conditions hold on the same sweep.
            if (stop_tol) converged <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_OUTPUT: begin
          out_valid <= 1'b1;
          x_out     <= x_mem[idx];
          idx       <= last_row ? '0 : idx + 1'b1;
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_band_solver.sv
// Self-checking bench for gsim_band_solver: four configurations driven independently.
// Inst 0: N=16 MAX_ITER=1; inst 1: N=16 MAX_ITER=255; inst 2: XW=24 MAX_ITER=1; inst 3: N=8 MAX_ITER=1.
module tb_gsim_band_solver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [3:0]        in_en;
  logic signed [15:0] b_in;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [3:0]        ov, bz, cv;
  logic [3:0][31:0]  xo;
  logic [3:0][7:0]   ic;
  logic signed [23:0] x2_raw;
  assign xo[2] = {{8{x2_raw[23]}}, x2_raw};

  gsim_band_solver #(.N(16), .MAX_ITER(1)) u_s1 (
    .clk(clk), .reset(reset), .in_en(in_en[0]), .b_in(b_in), .out_valid(ov[0]),
    .x_out(xo[0]), .busy(bz[0]), .iter_cnt(ic[0]), .converged(cv[0]));
  gsim_band_solver #(.N(16), .MAX_ITER(255)) u_conv (
    .clk(clk), .reset(reset), .in_en(in_en[1]), .b_in(b_in), .out_valid(ov[1]),
    .x_out(xo[1]), .busy(bz[1]), .iter_cnt(ic[1]), .converged(cv[1]));
  gsim_band_solver #(.N(16), .XW(24), .MAX_ITER(1)) u_sat (
    .clk(clk), .reset(reset), .in_en(in_en[2]), .b_in(b_in), .out_valid(ov[2]),
    .x_out(x2_raw), .busy(bz[2]), .iter_cnt(ic[2]), .converged(cv[2]));
  gsim_band_solver #(.N(8), .MAX_ITER(1)) u_n8 (
    .clk(clk), .reset(reset), .in_en(in_en[3]), .b_in(b_in), .out_valid(ov[3]),
    .x_out(xo[3]), .busy(bz[3]), .iter_cnt(ic[3]), .converged(cv[3]));

  int NI  [4] = '{16, 16, 16, 8};
  int XWI [4] = '{32, 32, 24, 32};
  int MII [4] = '{1, 255, 1, 1};

  int n_tests = 0;
  int n_fail  = 0;

  // Output burst capture
  int     cap_n     [4];
  int     cap_first [4];
  int     cap_last  [4];
  longint cap_x     [4][16];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ov[i]) begin
        if (cap_n[i] == 0) cap_first[i] = cyc;
        cap_last[i] = cyc;
        if (cap_n[i] < 16) cap_x[i][cap_n[i]] = longint'($signed(xo[i]));
        cap_n[i]++;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: plain Gauss-Seidel sweeps on 64-bit integers.
  longint m_x [16];
  int     m_it;
  bit     m_cv;

  function automatic longint xg(input longint x[16], input int n, input int j);
    if (j < 0 || j >= n) return 0;
    return x[j];
  endfunction

  task automatic model(input int inst, input longint bv[16]);
    longint x[16];
    longint num, xn, mx, d, hi, lo;
    int n;
    n  = NI[inst];
    hi = (longint'(1) <<< (XWI[inst] - 1)) - 1;
    lo = -hi - 1;
    for (int i = 0; i < 16; i++) x[i] = 0;
    m_it = 0;
    m_cv = 0;
    for (int s = 0; s < MII[inst]; s++) begin
      mx = 0;
      for (int i = 0; i < n; i++) begin
        num = bv[i] * 65536 + 13 * (xg(x, n, i-1) + xg(x, n, i+1))
              - 6 * (xg(x, n, i-2) + xg(x, n, i+2)) + xg(x, n, i-3) + xg(x, n, i+3);
        xn = num / 20;
        if (xn > hi) xn = hi;
        if (xn < lo) xn = lo;
        d = xn - x[i];
        if (d < 0) d = -d;
        if (d > mx) mx = d;
        x[i] = xn;
      end
      m_it = s + 1;
      if (mx <= 0) begin
        m_cv = 1;
        break;
      end
    end
    m_x = x;
  endtask

  task automatic load(input int inst, input longint bv[16], input int maxgap, output int last_acc);
    for (int k = 0; k < NI[inst]; k++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        in_en[inst] = 1'b0;
      end
      @(negedge clk);
      in_en[inst] = 1'b1;
      b_in = 16'(bv[k]);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_en[inst] = 1'b0;
  endtask

  task automatic run_problem(input int inst, input longint bv[16], input int maxgap, input bit noise);
    int last_acc, budget, n;
    bit done;
    n = NI[inst];
    model(inst, bv);
    cap_n[inst] = 0;
    load(inst, bv, maxgap, last_acc);
    budget = MII[inst] * n + n + 40;
    done = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (noise) begin
        in_en[inst] = bz[inst] & ($urandom_range(1, 0) == 1);
        b_in = 16'($urandom);
      end
      if (cap_n[inst] >= n && !ov[inst]) begin
        done = 1;
        break;
      end
    end
    in_en[inst] = 1'b0;
    chk($sformatf("i%0d burst_done", inst), done, 1);
    chk($sformatf("i%0d burst_len", inst), cap_n[inst], n);
    chk($sformatf("i%0d burst_contig", inst), cap_last[inst] - cap_first[inst], n - 1);
    chk($sformatf("i%0d latency", inst), cap_first[inst] - last_acc, m_it * n + 1);
    chk($sformatf("i%0d iter_cnt", inst), ic[inst], m_it);
    chk($sformatf("i%0d converged", inst), cv[inst], m_cv);
    chk($sformatf("i%0d busy_after", inst), bz[inst], 0);
    for (int i = 0; i < n; i++)
      chk($sformatf("i%0d x[%0d]", inst, i), cap_x[inst][i], m_x[i]);
  endtask

  function automatic real coef(input int d);
    case (d < 0 ? -d : d)
      0: return 20.0;
      1: return -13.0;
      2: return 6.0;
      3: return -1.0;
      default: return 0.0;
    endcase
  endfunction

  typedef struct {
    int     inst;
    longint b0;
    longint e0, e1, e2;
    int     eit;
    bit     ecv;
  } vec_t;

  initial begin
    vec_t   tbl [5];
    longint bv  [16];
    int     last_acc;
    real    r, acc;

    tbl[0] = '{0, 20,    65536,   42598,   8027,    1, 0};
    tbl[1] = '{0, 0,     0,       0,       0,       1, 1};
    tbl[2] = '{3, 20,    65536,   42598,   8027,    1, 0};
    tbl[3] = '{2, 32767, 8388607, 5452594, 1027604, 1, 0};
    tbl[4] = '{1, 0,     0,       0,       0,       1, 1};

    for (int i = 0; i < 4; i++) cap_n[i] = 0;
    reset = 1'b0;
    in_en = '0;
    b_in  = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("i%0d rst out_valid", i), ov[i], 0);
      chk($sformatf("i%0d rst x_out", i), xo[i], 0);
      chk($sformatf("i%0d rst busy", i), bz[i], 0);
      chk($sformatf("i%0d rst iter_cnt", i), ic[i], 0);
      chk($sformatf("i%0d rst converged", i), cv[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single-spike / zero vectors
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 16; i++) bv[i] = 0;
      bv[0] = tbl[t].b0;
      run_problem(tbl[t].inst, bv, 0, 0);
      chk($sformatf("tbl%0d x0", t), cap_x[tbl[t].inst][0], tbl[t].e0);
      chk($sformatf("tbl%0d x1", t), cap_x[tbl[t].inst][1], tbl[t].e1);
      chk($sformatf("tbl%0d x2", t), cap_x[tbl[t].inst][2], tbl[t].e2);
      chk($sformatf("tbl%0d iter", t), ic[tbl[t].inst], tbl[t].eit);
      chk($sformatf("tbl%0d conv", t), cv[tbl[t].inst], tbl[t].ecv);
    end

    // Known solution x = 1.0 everywhere
    bv = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    run_problem(1, bv, 0, 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("known x[%0d] near 1.0", i),
          (cap_x[1][i] >= 65536 - 256) && (cap_x[1][i] <= 65536 + 256), 1);

    // Regression pattern: residual of the converged solution
    bv = '{5, -3, 10, 0, 7, -8, 2, 1, -4, 6, 0, 3, -2, 9, -1, 4};
    run_problem(1, bv, 0, 0);
    acc = 0.0;
    for (int i = 0; i < 16; i++) begin
      r = -real'(bv[i]);
      for (int j = 0; j < 16; j++) r = r + coef(i - j) * real'(cap_x[1][j]) / 65536.0;
      acc = acc + r * r;
    end
    chk("regress residual<0.3", acc < 0.3, 1);

    // Back-to-back with input gaps and in_en noise while busy
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) bv[i] = longint'($signed(16'($urandom)));
      run_problem(0, bv, 3 * p, 1);
    end

    // Randomised problems on the other configurations
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) bv[i] = longint'($urandom_range(100, 0)) - 50;
      run_problem(1, bv, 1, 0);
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) bv[i] = longint'($signed(16'($urandom)));
      run_problem(2, bv, 2, 1);
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) bv[i] = longint'($signed(16'($urandom)));
      run_problem(3, bv, 1, 0);
    end

    // Reset in the middle of a solve: no stale burst, then a clean spike problem
    for (int i = 0; i < 16; i++) bv[i] = longint'($signed(16'($urandom)));
    cap_n[0] = 0;
    load(0, bv, 0, last_acc);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #2;
    chk("midrst busy", bz[0], 0);
    chk("midrst out_valid", ov[0], 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst no stale burst", cap_n[0], 0);
    for (int i = 0; i < 16; i++) bv[i] = 0;
    bv[0] = 20;
    run_problem(0, bv, 0, 0);
    chk("postrst x0", cap_x[0][0], 65536);
    chk("postrst x1", cap_x[0][1], 42598);
    chk("postrst x2", cap_x[0][2], 8027);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
